// File: rtl/cfi_pkg.sv
// Shared types and constants for the commit-side control-flow-integrity exception arbiter.
package cfi_pkg;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSTR = 64'd2;
    localparam logic [XLEN-1:0] CAUSE_BREAKPOINT    = 64'd3;

    localparam logic [1:0] CFG_CTRL   = 2'd0;
    localparam logic [1:0] CFG_THRESH = 2'd1;
    localparam logic [1:0] CFG_COUNT  = 2'd2;
    localparam logic [1:0] CFG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_MASK_LSB   = 1;
    localparam int unsigned CTRL_LOCK_BIT   = 31;
    localparam int unsigned STATUS_SRC_LSB  = 8;

    // Encoding is visible through STATUS, so it is pinned explicitly.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESENT  = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_LOCKED   = 2'd3
    } cfi_state_e;

endpackage

// File: rtl/cfi_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after the pointer, wrapping.
module cfi_rr_arbiter #(
    parameter int unsigned NR_SRC = 2,
    parameter int unsigned PTR_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1
) (
    input  logic [NR_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NR_SRC-1:0] gnt_o,
    output logic [PTR_W-1:0]  idx_o,
    output logic              valid_o
);

    int unsigned      sum;
    logic [PTR_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the loop, so no latch can be inferred.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = 0;
        cand    = '0;
        for (int unsigned off = 0; off < NR_SRC; off++) begin
            sum = 32'(ptr_i) + off;
            if (sum >= NR_SRC) begin
                sum = sum - NR_SRC;
            end
            cand = PTR_W'(sum);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/cfi_exc_arbiter.sv
// Collects checker exception pulses into sticky pending bits, presents one at a time to
// commit in round-robin order, counts violations and can lock the core past a threshold.
module cfi_exc_arbiter
    import cfi_pkg::*;
#(
    parameter int unsigned NR_SRC       = 2,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned COOLDOWN_CYC = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  exception_t [NR_SRC-1:0] src_exc_i,
    input  logic                    exc_ack_i,
    input  logic                    cfg_we_i,
    input  logic [1:0]              cfg_addr_i,
    input  logic [31:0]             cfg_wdata_i,
    output logic [31:0]             cfg_rdata_o,
    output exception_t              exception_o,
    output logic                    halt_o
);

    localparam int unsigned PTR_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned CD_W  = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    cfi_state_e              state_q, state_d;
    exception_t              exc_q, exc_d;
    logic [CD_W-1:0]         cd_q, cd_d;
    logic                    grant;

    logic [NR_SRC-1:0]       pend_q;
    exception_t [NR_SRC-1:0] payload_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [2:0]              last_src_q;

    logic                    global_en_q, lock_en_q;
    logic [NR_SRC-1:0]       mask_q;
    logic [CNT_W-1:0]        thresh_q, count_q;

    logic                    locked, ctrl_we, thresh_we, count_clr;
    logic [NR_SRC-1:0]       set_vec, cfg_clr, gnt_oh;
    logic [PTR_W-1:0]        gnt_idx;
    logic                    gnt_valid;
    logic                    unused_wdata;

    assign locked    = (state_q == ST_LOCKED);
    assign ctrl_we   = cfg_we_i && (cfg_addr_i == CFG_CTRL) && !locked;
    assign thresh_we = cfg_we_i && (cfg_addr_i == CFG_THRESH) && !locked;
    assign count_clr = cfg_we_i && (cfg_addr_i == CFG_COUNT);

    // A CTRL write that turns a source (or the global enable) off also drops its pending bit.
    assign cfg_clr = {NR_SRC{ctrl_we}} &
                     ~({NR_SRC{cfg_wdata_i[CTRL_EN_BIT]}} & cfg_wdata_i[CTRL_MASK_LSB +: NR_SRC]);

    assign unused_wdata = ^cfg_wdata_i[30:NR_SRC+1];

    always_comb begin
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            set_vec[i] = src_exc_i[i].valid & global_en_q & mask_q[i];
        end
    end

    cfi_rr_arbiter #(
        .NR_SRC (NR_SRC),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req_i   (pend_q),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt_oh),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            exc_q   <= '0;
            cd_q    <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cd_q    <= cd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        cd_d    = cd_q;
        grant   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant   = 1'b1;
                    exc_d   = payload_q[gnt_idx];
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (exc_ack_i) begin
                    exc_d.valid = 1'b0;
                    if (lock_en_q && (thresh_q != '0) && (count_q >= thresh_q)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_COOLDOWN;
                        cd_d    = '0;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cd_q == CD_W'(COOLDOWN_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cd_d = cd_q + CD_W'(1);
                end
            end
            ST_LOCKED: begin
                exc_d.valid = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new pulse on the source being granted keeps its pending bit alive with the new payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q     <= '0;
            ptr_q      <= '0;
            last_src_q <= '0;
            count_q    <= '0;
        end else begin
            pend_q <= ((pend_q & ~(grant ? gnt_oh : '0)) | set_vec) & ~cfg_clr;
            if (grant) begin
                ptr_q      <= (gnt_idx == PTR_W'(NR_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
                last_src_q <= 3'(gnt_idx);
                if (count_clr) begin
                    count_q <= CNT_W'(1);
                end else if (count_q != '1) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (count_clr) begin
                count_q <= '0;
            end
        end
    end

    // NOTE: payload storage has no reset; it is only ever read behind a set pending bit.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            if (set_vec[i]) begin
                payload_q[i] <= src_exc_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            global_en_q <= 1'b1;
            mask_q      <= '0;
            lock_en_q   <= 1'b0;
            thresh_q    <= '0;
        end else begin
            if (ctrl_we) begin
                global_en_q <= cfg_wdata_i[CTRL_EN_BIT];
                mask_q      <= cfg_wdata_i[CTRL_MASK_LSB +: NR_SRC];
                lock_en_q   <= cfg_wdata_i[CTRL_LOCK_BIT];
            end
            if (thresh_we) begin
                thresh_q <= cfg_wdata_i[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        unique case (cfg_addr_i)
            CFG_CTRL: begin
                cfg_rdata_o[CTRL_EN_BIT]              = global_en_q;
                cfg_rdata_o[CTRL_MASK_LSB +: NR_SRC]  = mask_q;
                cfg_rdata_o[CTRL_LOCK_BIT]            = lock_en_q;
            end
            CFG_THRESH: cfg_rdata_o[CNT_W-1:0] = thresh_q;
            CFG_COUNT:  cfg_rdata_o[CNT_W-1:0] = count_q;
            default: begin
                cfg_rdata_o[1:0]                  = state_q;
                cfg_rdata_o[STATUS_SRC_LSB +: 3]  = last_src_q;
            end
        endcase
    end

    assign exception_o = exc_q;
    assign halt_o      = locked;

endmodule

// File: tb/tb_cfi_exc_arbiter.sv
// Self-checking bench for cfi_exc_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_cfi_exc_arbiter;
    import cfi_pkg::*;

    localparam int NS      = 2;
    localparam int CW      = 5;   // narrow counter so saturation is reachable in a short run
    localparam int CD      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    exception_t [NS-1:0] src_exc;
    logic              exc_ack;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [31:0]       cfg_rdata;
    exception_t        exc_out;
    logic              halt;

    int checks = 0;
    int errors = 0;

    cfi_exc_arbiter #(
        .NR_SRC       (NS),
        .CNT_W        (CW),
        .COOLDOWN_CYC (CD)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .src_exc_i   (src_exc),
        .exc_ack_i   (exc_ack),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .exception_o (exc_out),
        .halt_o      (halt)
    );

    always #5 clk = ~clk;

    // Reference model: pending flags, latched payloads, a "next preferred source" number,
    // and the clock-edge number after which grants may resume.
    bit          m_pend [NS];
    logic [63:0] m_cause[NS];
    logic [63:0] m_tval [NS];
    bit          m_en, m_lock_en, m_locked, m_busy, m_ovalid;
    bit [NS-1:0] m_mask;
    logic [63:0] m_ocause, m_otval;
    int          m_ptr, m_count, m_thresh, m_last, m_edge, m_cool_end;

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) m_pend[i] = 1'b0;
        m_en = 1'b1; m_mask = '0; m_lock_en = 1'b0; m_locked = 1'b0;
        m_busy = 1'b0; m_ovalid = 1'b0; m_ocause = '0; m_otval = '0;
        m_ptr = 0; m_count = 0; m_thresh = 0; m_last = 0; m_edge = 0; m_cool_end = -1;
    endfunction

    // Predicts the effect of the coming rising edge from the inputs currently driven.
    task automatic model_step();
        bit set_v[NS];
        int w, old_count;
        bit old_locked;
        if (rst) begin
            model_reset();
            return;
        end
        m_edge++;
        old_count  = m_count;
        old_locked = m_locked;
        for (int i = 0; i < NS; i++) set_v[i] = src_exc[i].valid && m_en && m_mask[i];
        w = -1;
        if (!m_busy && !m_locked && m_edge > m_cool_end) begin
            for (int k = 0; k < NS; k++) begin
                int c;
                c = (m_ptr + k) % NS;
                if (w < 0 && m_pend[c]) w = c;
            end
        end
        if (w >= 0) begin
            m_busy = 1'b1; m_ovalid = 1'b1;
            m_ocause = m_cause[w]; m_otval = m_tval[w];
            m_pend[w] = 1'b0; m_ptr = (w + 1) % NS; m_last = w;
            if (cfg_we && cfg_addr == 2'd2) m_count = 1;
            else if (m_count < CNT_MAX) m_count = m_count + 1;
        end else begin
            if (cfg_we && cfg_addr == 2'd2) m_count = 0;
            if (m_busy && exc_ack) begin
                m_busy = 1'b0; m_ovalid = 1'b0;
                if (m_lock_en && m_thresh != 0 && old_count >= m_thresh) m_locked = 1'b1;
                else m_cool_end = m_edge + CD;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (set_v[i]) begin
                m_pend[i] = 1'b1; m_cause[i] = src_exc[i].cause; m_tval[i] = src_exc[i].tval;
            end
        end
        if (cfg_we && cfg_addr == 2'd0 && !old_locked) begin
            for (int i = 0; i < NS; i++) if (!cfg_wdata[0] || !cfg_wdata[i+1]) m_pend[i] = 1'b0;
            m_en = cfg_wdata[0]; m_mask = cfg_wdata[NS:1]; m_lock_en = cfg_wdata[31];
        end
        if (cfg_we && cfg_addr == 2'd1 && !old_locked) m_thresh = int'(cfg_wdata[CW-1:0]);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        if (m_locked) s[1:0] = 2'd3;
        else if (m_busy) s[1:0] = 2'd1;
        else if (m_edge < m_cool_end) s[1:0] = 2'd2;
        s[10:8] = 3'(m_last);
        return s;
    endfunction

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic pulse(input logic [NS-1:0] which, input logic [63:0] c0, input logic [63:0] c1);
        for (int i = 0; i < NS; i++) begin
            src_exc[i].valid = which[i];
            src_exc[i].cause = (i == 0) ? c0 : c1;
            src_exc[i].tval  = {$urandom, $urandom};
        end
        tick();
        for (int i = 0; i < NS; i++) src_exc[i].valid = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = (exc_out.valid === 1'b1);
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (exc_out.valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic ack_once();
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; exc_ack = 1'b0; cfg_we = 1'b0;
        for (int i = 0; i < NS; i++) src_exc[i] = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++;
        if (exc_out !== '0 || halt !== 1'b0)
            $display("FAIL reset_outputs got exc=%h halt=%b want exc=0 halt=0", exc_out, halt);
        else checks += 0;
        if (exc_out !== '0 || halt !== 1'b0) errors++;
        cfg_read(CFG_CTRL, d);   checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h want 00000001", d); end
        cfg_read(CFG_THRESH, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_thresh got %h want 0", d); end
        cfg_read(CFG_COUNT, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_count got %h want 0", d); end
        cfg_read(CFG_STATUS, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [63:0] tv;
        do_reset();
        cfg_write(CFG_CTRL, 32'h7);
        pulse(2'b01, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
        tv = src_exc[0].tval;
        checks++;
        if (exc_out.valid !== 1'b0) begin errors++; $display("FAIL basic_latency1 got valid=%b want 0", exc_out.valid); end
        tick();
        checks++;
        if (exc_out.valid !== 1'b1 || exc_out.cause !== CAUSE_BREAKPOINT || exc_out.tval !== tv) begin
            errors++; $display("FAIL basic_present got v=%b c=%h t=%h want v=1 c=%h t=%h",
                               exc_out.valid, exc_out.cause, exc_out.tval, CAUSE_BREAKPOINT, tv);
        end
        repeat (3) begin
            tick();
            checks++;
            if (exc_out.valid !== 1'b1 || exc_out.cause !== CAUSE_BREAKPOINT || exc_out.tval !== tv) begin
                errors++; $display("FAIL basic_hold got v=%b c=%h t=%h want held", exc_out.valid, exc_out.cause, exc_out.tval);
            end
        end
        ack_once();
        checks++;
        if (exc_out.valid !== 1'b0) begin errors++; $display("FAIL basic_ack got valid=%b want 0", exc_out.valid); end
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL basic_count got %0d want 1", d); end
    endtask

    task automatic test_two_src();
        logic [31:0] d;
        logic [63:0] tv1;
        do_reset();
        cfg_write(CFG_CTRL, 32'h7);
        pulse(2'b11, CAUSE_BREAKPOINT, CAUSE_ILLEGAL_INSTR);
        tv1 = src_exc[1].tval;
        tick();
        checks++;
        if (exc_out.valid !== 1'b1 || exc_out.cause !== CAUSE_BREAKPOINT) begin
            errors++; $display("FAIL two_first got v=%b c=%h want v=1 c=%h", exc_out.valid, exc_out.cause, CAUSE_BREAKPOINT);
        end
        ack_once();
        cfg_read(CFG_STATUS, d);
        checks++; if (d[1:0] !== 2'd2) begin errors++; $display("FAIL two_cooldown_state got %0d want 2", d[1:0]); end
        for (int i = 0; i < CD; i++) begin
            tick();
            checks++;
            if (exc_out.valid !== 1'b0) begin errors++; $display("FAIL two_gap%0d got valid=1 want 0", i); end
        end
        tick();
        checks++;
        if (exc_out.valid !== 1'b1 || exc_out.cause !== CAUSE_ILLEGAL_INSTR || exc_out.tval !== tv1) begin
            errors++; $display("FAIL two_second got v=%b c=%h t=%h want v=1 c=%h t=%h",
                               exc_out.valid, exc_out.cause, exc_out.tval, CAUSE_ILLEGAL_INSTR, tv1);
        end
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL two_count got %0d want 2", d); end
        cfg_read(CFG_STATUS, d);
        checks++; if (d !== 32'h101) begin errors++; $display("FAIL two_status got %h want 00000101", d); end
        ack_once();
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        cfg_write(CFG_CTRL, 32'h3);
        pulse(2'b10, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
        repeat (4) tick();
        checks++; if (exc_out.valid !== 1'b0) begin errors++; $display("FAIL mask_blocked got valid=1 want 0"); end
        cfg_write(CFG_CTRL, 32'h7);
        repeat (4) tick();
        checks++; if (exc_out.valid !== 1'b0) begin errors++; $display("FAIL mask_reenable got valid=1 want 0"); end
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mask_count got %0d want 0", d); end
    endtask

    task automatic test_lock();
        logic [31:0] d;
        bit ok;
        do_reset();
        cfg_write(CFG_CTRL, 32'h8000_0007);
        cfg_write(CFG_THRESH, 32'd3);
        for (int v = 1; v <= 3; v++) begin
            pulse(2'b01, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
            wait_valid(10, ok);
            checks++; if (!ok) begin errors++; $display("FAIL lock_wait%0d got no valid want valid within 10", v); end
            ack_once();
            checks++;
            if (halt !== (v == 3)) begin errors++; $display("FAIL lock_halt%0d got %b want %b", v, halt, v == 3); end
        end
        cfg_read(CFG_STATUS, d);
        checks++; if (d[1:0] !== 2'd3) begin errors++; $display("FAIL lock_state got %0d want 3", d[1:0]); end
        pulse(2'b11, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
        repeat (6) tick();
        checks++; if (exc_out.valid !== 1'b0) begin errors++; $display("FAIL lock_nogrant got valid=1 want 0"); end
        cfg_write(CFG_CTRL, 32'h0);
        cfg_read(CFG_CTRL, d);
        checks++; if (d !== 32'h8000_0007) begin errors++; $display("FAIL lock_ctrl_wr got %h want 80000007", d); end
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL lock_count got %0d want 3", d); end
        do_reset();
        cfg_read(CFG_COUNT, d);
        checks++;
        if (halt !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL lock_reset got halt=%b count=%0d want 0 0", halt, d); end
    endtask

    task automatic test_saturate();
        logic [31:0] d;
        bit ok;
        int lost;
        do_reset();
        cfg_write(CFG_CTRL, 32'h7);
        lost = 0;
        for (int v = 0; v < CNT_MAX + 2; v++) begin
            pulse(2'b01, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
            wait_valid(10, ok);
            if (!ok) lost++;
            ack_once();
        end
        checks++; if (lost != 0) begin errors++; $display("FAIL sat_wait got %0d timeouts want 0", lost); end
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'(CNT_MAX)) begin errors++; $display("FAIL sat_count got %0d want %0d", d, CNT_MAX); end
        repeat (4) tick();
        pulse(2'b01, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
        cfg_write(CFG_COUNT, 32'h0);
        checks++; if (exc_out.valid !== 1'b1) begin errors++; $display("FAIL sat_grant got valid=0 want 1"); end
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL sat_clr_grant got %0d want 1", d); end
        ack_once();
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bit ok;
        do_reset();
        cfg_write(CFG_CTRL, 32'h7);
        pulse(2'b10, CAUSE_BREAKPOINT, CAUSE_BREAKPOINT);
        wait_valid(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_wait got no valid want valid within 10"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (exc_out.valid !== 1'b0 || halt !== 1'b0) begin
            errors++; $display("FAIL arst_immediate got valid=%b halt=%b want 0 0", exc_out.valid, halt);
        end
        model_reset();
        tick();
        rst = 1'b0;
        cfg_read(CFG_COUNT, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL arst_count got %0d want 0", d); end
        cfg_read(CFG_CTRL, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL arst_ctrl got %h want 00000001", d); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int r;
        bit ctrl_wr;
        do_reset();
        cfg_write(CFG_CTRL, 32'h7);
        for (int c = 0; c < 600; c++) begin
            if (m_locked && ($urandom % 16 == 0)) begin
                do_reset();
                cfg_write(CFG_CTRL, 32'h7);
            end
            r = $urandom_range(0, 99);
            ctrl_wr = 1'b0;
            cfg_we = 1'b0;
            if (r < 5) begin
                ctrl_wr = 1'b1;
                cfg_we = 1'b1; cfg_addr = CFG_CTRL;
                cfg_wdata = '0;
                cfg_wdata[0] = ($urandom % 5 != 0);
                cfg_wdata[NS:1] = NS'($urandom);
                cfg_wdata[31] = ($urandom % 6 == 0);
            end else if (r < 8) begin
                cfg_we = 1'b1; cfg_addr = CFG_COUNT; cfg_wdata = $urandom;
            end else if (r < 10) begin
                cfg_we = 1'b1; cfg_addr = CFG_THRESH; cfg_wdata = $urandom_range(0, 12);
            end
            for (int i = 0; i < NS; i++) begin
                src_exc[i].valid = !ctrl_wr && ($urandom % 4 == 0);
                src_exc[i].cause = 64'($urandom_range(0, 15));
                src_exc[i].tval  = {$urandom, $urandom};
            end
            exc_ack = ($urandom % 3 == 0);
            tick();
            cfg_we = 1'b0; exc_ack = 1'b0;
            for (int i = 0; i < NS; i++) src_exc[i].valid = 1'b0;
            checks++;
            if (exc_out.valid !== m_ovalid || halt !== m_locked ||
                (m_ovalid && (exc_out.cause !== m_ocause || exc_out.tval !== m_otval))) begin
                errors++;
                $display("FAIL rand_exc cyc %0d got v=%b c=%h t=%h h=%b want v=%b c=%h t=%h h=%b",
                         c, exc_out.valid, exc_out.cause, exc_out.tval, halt, m_ovalid, m_ocause, m_otval, m_locked);
            end
            cfg_read(CFG_STATUS, d);
            checks++;
            if (d !== model_status()) begin errors++; $display("FAIL rand_status cyc %0d got %h want %h", c, d, model_status()); end
            cfg_read(CFG_COUNT, d);
            checks++;
            if (d !== 32'(m_count)) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, d, m_count); end
        end
    endtask

    initial begin
        exc_ack = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        for (int i = 0; i < NS; i++) src_exc[i] = '0;
        model_reset();
        test_reset();
        test_basic();
        test_two_src();
        test_mask();
        test_lock();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
